// File: rtl/noc_pkg.sv
// Shared constants and types for the 5-port mesh router.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int SEL_W     = 3;

    typedef logic [SEL_W-1:0] port_idx_t;

    localparam port_idx_t PORT_N    = 3'd0;
    localparam port_idx_t PORT_S    = 3'd1;
    localparam port_idx_t PORT_E    = 3'd2;
    localparam port_idx_t PORT_W    = 3'd3;
    localparam port_idx_t PORT_L    = 3'd4;
    localparam port_idx_t PORT_NONE = 3'd7;

    // Round-robin successor of a port index, wrapping L back to N.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == PORT_L) ? PORT_N : port_idx_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the allocator and the crossbar.
interface switch_allocator_if
    import noc_pkg::*;
();

    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS*SEL_W-1:0] req_port;
    logic [NUM_PORTS-1:0]       req_last;
    logic [NUM_PORTS-1:0]       out_ready;
    logic [NUM_PORTS-1:0]       in_grant;
    logic [NUM_PORTS*SEL_W-1:0] out_sel;
    logic [NUM_PORTS-1:0]       out_valid;
    logic                       err_bad_port;

    // Router side: presents requests and downstream readiness.
    modport master (
        output req_valid, req_port, req_last, out_ready,
        input  in_grant, out_sel, out_valid, err_bad_port
    );

    // Allocator side.
    modport slave (
        input  req_valid, req_port, req_last, out_ready,
        output in_grant, out_sel, out_valid, err_bad_port
    );

endinterface

// File: rtl/switch_allocator_rr_arb5.sv
// Combinational 5-way round-robin arbiter: first request at or above rr_ptr wins.
module rr_arb5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            rr_ptr,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] gnt,
    output port_idx_t            winner
);

    logic       found;
    logic [3:0] pos;

    // Search from rr_ptr upward with wrap, stopping at the first request.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt    = '0;
        winner = PORT_NONE;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pos = {1'b0, rr_ptr} + 4'(k);
            if (pos >= 4'(NUM_PORTS)) begin
                pos = pos - 4'(NUM_PORTS);
            end
            if (en && !found && req[pos[2:0]]) begin
                found            = 1'b1;
                gnt[pos[2:0]]    = 1'b1;
                winner           = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-cycle switch allocator: one round-robin arbiter per output with
// wormhole locking so multi-flit packets never interleave on an output.
module switch_allocator
    import noc_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    switch_allocator_if.slave  bus
);

    port_idx_t rr_ptr [NUM_PORTS];
    logic      lock   [NUM_PORTS];
    port_idx_t owner  [NUM_PORTS];
    logic      err_q;

    port_idx_t                              req_port_a [NUM_PORTS];
    logic [NUM_PORTS-1:0]                   eligible   [NUM_PORTS];
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    gnt;
    port_idx_t [NUM_PORTS-1:0]              winner;
    logic [NUM_PORTS-1:0]                   arb_en;
    logic [NUM_PORTS-1:0]                   tail;
    logic                                   bad_req;

    // Build per-output candidate sets, restricted to the owner while locked, and flag illegal targets.
    always_comb begin
        bad_req = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_port_a[i] = bus.req_port[i*SEL_W +: SEL_W];
            if (bus.req_valid[i] && (req_port_a[i] > PORT_L)) begin
                bad_req = 1'b1;
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            eligible[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.req_valid[i] && (req_port_a[i] == port_idx_t'(o))
                    && (!lock[o] || (owner[o] == port_idx_t'(i)))) begin
                    eligible[o][i] = 1'b1;
                end
            end
            // Reset and a stalled downstream both suppress the grant outright.
            arb_en[o] = bus.out_ready[o] && !reset;
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arb5 u_arb (
            .req    (eligible[o]),
            .rr_ptr (rr_ptr[o]),
            .en     (arb_en[o]),
            .gnt    (gnt[o]),
            .winner (winner[o])
        );
    end

    // Fold per-output grants into crossbar selects, input grants and tail detection.
    always_comb begin
        bus.in_grant = '0;
        bus.out_sel  = '0;
        bus.out_valid = '0;
        tail         = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            bus.out_valid[o]              = |gnt[o];
            bus.out_sel[o*SEL_W +: SEL_W] = winner[o];
            bus.in_grant                  = bus.in_grant | gnt[o];
            // With locking disabled every flit behaves as a tail.
            tail[o] = !LOCK_EN || (|(gnt[o] & bus.req_last));
        end
    end

    assign bus.err_bad_port = err_q && !reset;

    // Advance lock/owner/round-robin state on each transfer; synchronous reset drops any open packet.
    always_ff @(posedge clk) begin
        // NOTE: the state here is a handful of flops, so the whole array is reset; non-blocking assignments keep every update based on this cycle's values.
        if (reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                rr_ptr[o] <= PORT_N;
                lock[o]   <= 1'b0;
                owner[o]  <= PORT_NONE;
            end
            err_q <= 1'b0;
        end else begin
            err_q <= bad_req;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (bus.out_valid[o]) begin
                    if (tail[o]) begin
                        lock[o]   <= 1'b0;
                        owner[o]  <= PORT_NONE;
                        rr_ptr[o] <= next_port(winner[o]);
                    end else if (!lock[o]) begin
                        lock[o]   <= 1'b1;
                        owner[o]  <= winner[o];
                    end
                end
            end
        end
    end

endmodule
